// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial borrow subtractor.
// FSM state encoding and counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - yb - bi.
// Ports: x, yb, bi in; d difference, bo borrow out.
module full_subtractor (
  input  logic x,
  input  logic yb,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic p;

  assign p  = x ^ yb;
  assign d  = p ^ bi;
  assign bo = (~x & yb) | (~p & bi);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial n-bit subtractor y = a - b - bin, LSB first.
// Ports: clk, rst_n, start/a/b/bin in; busy, done, y, bout, borrows, ovf out.
module serial_borrow_subtractor
  import serial_sub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] y,
  output logic         bout,
  output logic [n:0]   borrows,
  output logic         ovf
);

  localparam int CW = cnt_w(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  a_q, a_d;
  logic [n-1:0]  b_q, b_d;
  logic          br_q, br_d;
  logic [n-1:0]  sy_q, sy_d;
  logic [n:0]    sb_q, sb_d;
  logic [n-1:0]  y_q, y_d;
  logic [n:0]    bw_q, bw_d;

  logic fs_d, fs_bo;

  full_subtractor u_fs (
    .x  (a_q[cnt_q]),
    .yb (b_q[cnt_q]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    sy_d    = sy_q;
    sb_d    = sb_q;
    y_d     = y_q;
    bw_d    = bw_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          sy_d    = '0;
          sb_d    = '0;
          sb_d[0] = bin;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < n; i++) begin
          if (cnt_q == CW'(i)) begin
            sy_d[i]   = fs_d;
            sb_d[i+1] = fs_bo;
          end
        end
        br_d  = fs_bo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Publish only complete results.
          state_d = DONE;
          cnt_d   = '0;
          y_d     = sy_d;
          bw_d    = sb_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      sy_q    <= '0;
      sb_q    <= '0;
      y_q     <= '0;
      bw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      sy_q    <= sy_d;
      sb_q    <= sb_d;
      y_q     <= y_d;
      bw_q    <= bw_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign y       = y_q;
  assign borrows = bw_q;
  assign bout    = bw_q[n];
  assign ovf     = bw_q[n] ^ bw_q[n-1];

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Multi-cycle, bit-serial n-bit subtractor: y = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell.
- Counterpart to the ripple-carry adder (rcaM). Exposes the complete borrow chain, as the adder exposes its carry chain, so datapath checks can compare adder and subtractor stage by stage.
- Sits beside rcaM in the arithmetic datapath and takes operands through a start/done handshake.

Parameters:
- n, 4, operand and result width in bits (n >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  n  minuend; captured when start is accepted.
- b  input  n  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- y  output  n  difference (a - b - bin) mod 2^n.
- bout  output  1  final borrow, equal to borrows[n].
- borrows  output  n+1  borrow chain; borrows[0]=bin, borrows[i+1] is the borrow out of bit i.
- ovf  output  1  signed overflow, equal to borrows[n] ^ borrows[n-1].

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, bit counter=0, internal registers=0.
  - Outputs: busy=0, done=0, y=0, bout=0, borrows=0, ovf=0.
  - Reset asserted mid-operation aborts the operation; no done pulse is ever produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: capture a, b, bin; set working borrow=bin and shadow borrows[0]=bin; clear counter; go to RUN with busy=1.
- RUN (counter i = 0..n-1), on each edge:
  - d = a[i] ^ b[i] ^ br.
  - br' = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br).
  - Shadow y[i]=d, shadow borrows[i+1]=br'; counter increments.
  - After the edge that processes i=n-1: go to DONE.
  - start is ignored in RUN; captured operands do not change.
- DONE:
  - Publish the shadow result to y, borrows, bout and ovf on entry.
  - busy=0, done=1 for exactly this one cycle.
  - Next edge: go to IDLE, or, if start=1, accept the new operands immediately and go to RUN (back-to-back; done falls).
- Output stability:
  - y, bout, borrows and ovf change only on entry to DONE. Between results they hold the last published values; no partial results are ever visible.
- Latency: start accepted at edge k; done is high in the cycle after edge k+n; RUN lasts n cycles.
- Throughput: one result per n+1 cycles.
- Width rules: all arithmetic is mod 2^n; the counter is $clog2(n) bits wide and never runs past n-1.
- Input changes on a, b or bin after capture have no effect on the operation in progress.

Decomposition:
- Package serial_sub_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Function or localparam for the counter width $clog2(n).
- Sub-module full_subtractor:
  - Purely combinational 1-bit cell.
  - Inputs x, yb, bi; outputs d, bo.
  - Instantiated once in the serial datapath.

Test Plan:
- n=4, a=0111, b=0101, bin=0, start pulse -> after 5 cycles done=1, y=0010, bout=0, borrows=00000, ovf=0.
- a=0111, b=1011, bin=1 -> y=1011, bout=1, borrows=10111, ovf=1.
- a=0000, b=0000, bin=1 -> y=1111, bout=1, borrows=11111, ovf=0 (wrap-around of the borrow chain).
- a=1000, b=0001, bin=0 -> y=0111, bout=0, borrows=01110, ovf=1 (signed overflow).
- Pulse start again 2 cycles into RUN with different operands -> ignored; the first result is delivered unchanged; back-to-back start during done is accepted, giving the next done exactly 5 cycles later.
- Assert rst_n=0 during RUN -> outputs read 0 immediately (asynchronous); no done pulse; a fresh start after release gives the correct result.
